// File: rtl/multicycle_controller.sv
// Multicycle control unit for an RV32I subset (R, I-ALU, LOAD, STORE, BEQ/BNE).
// Sequences FETCH/DECODE/EXEC/MEM/WB, halts in TRAP on unknown opcodes, counts retirements.
module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  inst_control,
    input  logic [9:0]  inst_alu,
    input  logic        zero_flag,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        sel,
    output logic        sel2,
    output logic        regw,
    output logic        alu_src,
    output logic        memw,
    output logic        memr,
    output logic [3:0]  alu_op,
    output logic        trap,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_I      = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5
    } insn_class_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    state_t      state;
    logic [6:0]  opcode_q;
    logic [9:0]  funct_q;
    insn_class_t insn_class;
    logic [3:0]  alu_code;
    logic        uses_imm;

    // ALU operation for the latched instruction. Only the exact alternate funct7
    // (0100000) turns ADD into SUB or a right shift into SRA; I-ALU never subtracts.
    function automatic logic [3:0] decode_alu(input insn_class_t cls, input logic [9:0] funct);
        logic [2:0] funct3;
        logic       alt;
        logic [3:0] code;
        funct3 = funct[2:0];
        alt    = (funct[9:3] == FUNCT7_ALT);
        code   = ALU_AND;
        case (cls)
            CLS_LOAD, CLS_STORE: code = ALU_ADD;
            CLS_BRANCH:          code = ALU_SUB;
            CLS_R, CLS_I: begin
                case (funct3)
                    3'b000:         code = (cls == CLS_R && alt) ? ALU_SUB : ALU_ADD;
                    3'b001:         code = ALU_SLL;
                    3'b010, 3'b011: code = ALU_SLT;
                    3'b100:         code = ALU_XOR;
                    3'b101:         code = alt ? ALU_SRA : ALU_SRL;
                    3'b110:         code = ALU_OR;
                    default:        code = ALU_AND;
                endcase
            end
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    // Classify the latched opcode; anything unrecognised is CLS_NONE and traps.
    always_comb begin
        insn_class = CLS_NONE;
        case (opcode_q)
            OPC_R:      insn_class = CLS_R;
            OPC_I:      insn_class = CLS_I;
            OPC_LOAD:   insn_class = CLS_LOAD;
            OPC_STORE:  insn_class = CLS_STORE;
            OPC_BRANCH: insn_class = CLS_BRANCH;
            default:    insn_class = CLS_NONE;
        endcase
    end

    assign alu_code = decode_alu(insn_class, funct_q);
    assign uses_imm = (insn_class == CLS_I) || (insn_class == CLS_LOAD) || (insn_class == CLS_STORE);

    // Sequencer. The instruction fields are captured only when leaving FETCH so the
    // fetch bus may change freely while the instruction is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            opcode_q <= '0;
            funct_q  <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    opcode_q <= inst_control;
                    funct_q  <= inst_alu;
                    state    <= S_DECODE;
                end
                S_DECODE: state <= (insn_class == CLS_NONE) ? S_TRAP : S_EXEC;
                S_EXEC: begin
                    case (insn_class)
                        CLS_R, CLS_I:        state <= S_WB;
                        CLS_LOAD, CLS_STORE: state <= S_MEM;
                        default:             state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready)
                        state <= (insn_class == CLS_LOAD) ? S_WB : S_FETCH;
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Output decode from the registered state and latched fields. The only input
    // terms are zero_flag (branch target select) and mem_ready (store completion),
    // both of which must act within the same cycle.
    always_comb begin
        pc_en   = 1'b0;
        sel     = 1'b0;
        sel2    = 1'b0;
        regw    = 1'b0;
        alu_src = 1'b0;
        memw    = 1'b0;
        memr    = 1'b0;
        alu_op  = ALU_AND;
        trap    = 1'b0;
        case (state)
            S_EXEC: begin
                alu_op  = alu_code;
                alu_src = uses_imm;
                if (insn_class == CLS_BRANCH) begin
                    pc_en = 1'b1;
                    case (funct_q[2:0])
                        3'b000:  sel = zero_flag;
                        3'b001:  sel = ~zero_flag;
                        default: sel = 1'b0;
                    endcase
                end
            end
            S_MEM: begin
                alu_op  = alu_code;
                alu_src = uses_imm;
                memr    = (insn_class == CLS_LOAD);
                memw    = (insn_class == CLS_STORE);
                pc_en   = (insn_class == CLS_STORE) && mem_ready;
            end
            S_WB: begin
                alu_op  = alu_code;
                alu_src = uses_imm;
                regw    = 1'b1;
                sel2    = (insn_class == CLS_LOAD);
                pc_en   = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    // Every instruction raises pc_en exactly once, so this counts retirements.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            retired <= '0;
        else if (pc_en)
            retired <= retired + 16'd1;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through
// its state sequence and checks strobes, ALU codes, retirement count and reset.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  inst_control;
    logic [9:0]  inst_alu;
    logic        zero_flag;
    logic        mem_ready;
    logic        pc_en, sel, sel2, regw, alu_src, memw, memr, trap;
    logic [3:0]  alu_op;
    logic [15:0] retired;
    logic [11:0] outs;

    int vectors     = 0;
    int miscompares = 0;
    logic [15:0] exp_retired = 16'd0;

    localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, XOR_ = 4'b0011;
    localparam logic [3:0] SLL = 4'b0100, SRL = 4'b0101, SUB = 4'b0110, SRA = 4'b0111, SLT = 4'b1000;
    localparam logic [11:0] IDLE = 12'h000;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .inst_control(inst_control), .inst_alu(inst_alu),
        .zero_flag(zero_flag), .mem_ready(mem_ready), .pc_en(pc_en), .sel(sel),
        .sel2(sel2), .regw(regw), .alu_src(alu_src), .memw(memw), .memr(memr),
        .alu_op(alu_op), .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    assign outs = {pc_en, sel, sel2, regw, alu_src, memw, memr, trap, alu_op};

    function automatic logic [11:0] pk(input logic pc, input logic s, input logic s2,
                                       input logic rw, input logic src, input logic mw,
                                       input logic mr, input logic tr, input logic [3:0] op);
        return {pc, s, s2, rw, src, mw, mr, tr, op};
    endfunction

    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_outs(input string tag, input logic [11:0] expected);
        check_output(tag, {4'h0, outs}, {4'h0, expected});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic [6:0] op, input logic [9:0] funct);
        inst_control = op;
        inst_alu     = funct;
    endtask

    // R / I-ALU instruction: FETCH -> DECODE -> EXEC -> WB -> FETCH.
    task automatic run_alu_insn(input string tag, input logic [6:0] op, input logic [9:0] funct,
                                input logic [3:0] exp_op, input logic exp_src);
        apply_stimulus(op, funct);
        tick();
        apply_stimulus(7'h7F, 10'h3FF);
        check_outs({tag, " decode"}, IDLE);
        tick();
        check_outs({tag, " exec"}, pk(0, 0, 0, 0, exp_src, 0, 0, 0, exp_op));
        tick();
        check_outs({tag, " wb"}, pk(1, 0, 0, 1, exp_src, 0, 0, 0, exp_op));
        tick();
        exp_retired = exp_retired + 16'd1;
        check_outs({tag, " fetch"}, IDLE);
        check_output({tag, " retired"}, retired, exp_retired);
    endtask

    initial begin
        rst = 1'b0;
        zero_flag = 1'b0;
        mem_ready = 1'b0;
        apply_stimulus(7'b0110011, 10'b0);
        #2;
        check_outs("reset outs", IDLE);
        check_output("reset retired", retired, 16'd0);
        @(posedge clk);
        #2;
        check_outs("reset held outs", IDLE);
        rst = 1'b1;

        run_alu_insn("R add",   7'b0110011, 10'b0000000_000, ADD, 1'b0);
        run_alu_insn("R sub",   7'b0110011, 10'b0100000_000, SUB, 1'b0);
        run_alu_insn("R sra",   7'b0110011, 10'b0100000_101, SRA, 1'b0);
        run_alu_insn("R sll",   7'b0110011, 10'b0000000_001, SLL, 1'b0);
        run_alu_insn("R xor",   7'b0110011, 10'b0000000_100, XOR_, 1'b0);
        run_alu_insn("R and",   7'b0110011, 10'b0000000_111, AND_, 1'b0);
        run_alu_insn("R slt",   7'b0110011, 10'b0000000_010, SLT, 1'b0);
        run_alu_insn("I addi",  7'b0010011, 10'b0100000_000, ADD, 1'b1);
        run_alu_insn("I srai",  7'b0010011, 10'b0100000_101, SRA, 1'b1);
        run_alu_insn("I srli",  7'b0010011, 10'b0000000_101, SRL, 1'b1);
        run_alu_insn("I ori",   7'b0010011, 10'b1010101_110, OR_, 1'b1);

        // LOAD with three wait cycles
        apply_stimulus(7'b0000011, 10'b0000000_010);
        mem_ready = 1'b0;
        tick();
        apply_stimulus(7'h7F, 10'h3FF);
        check_outs("load decode", IDLE);
        tick();
        check_outs("load exec", pk(0, 0, 0, 0, 1, 0, 0, 0, ADD));
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_outs($sformatf("load mem wait%0d", i), pk(0, 0, 0, 0, 1, 0, 1, 0, ADD));
        end
        tick();
        mem_ready = 1'b1;
        #1;
        check_outs("load mem ready", pk(0, 0, 0, 0, 1, 0, 1, 0, ADD));
        tick();
        mem_ready = 1'b0;
        check_outs("load wb", pk(1, 0, 1, 1, 1, 0, 0, 0, ADD));
        tick();
        exp_retired = exp_retired + 16'd1;
        check_outs("load fetch", IDLE);
        check_output("load retired", retired, exp_retired);

        // STORE completing in its first MEM cycle
        apply_stimulus(7'b0100011, 10'b0000000_010);
        tick();
        check_outs("store decode", IDLE);
        tick();
        check_outs("store exec", pk(0, 0, 0, 0, 1, 0, 0, 0, ADD));
        mem_ready = 1'b1;
        tick();
        check_outs("store mem", pk(1, 0, 0, 0, 1, 1, 0, 0, ADD));
        tick();
        mem_ready = 1'b0;
        exp_retired = exp_retired + 16'd1;
        check_outs("store fetch", IDLE);
        check_output("store retired", retired, exp_retired);

        // BEQ
        apply_stimulus(7'b1100011, 10'b0000000_000);
        tick();
        tick();
        zero_flag = 1'b1;
        #1;
        check_outs("beq taken", pk(1, 1, 0, 0, 0, 0, 0, 0, SUB));
        zero_flag = 1'b0;
        #1;
        check_outs("beq not taken", pk(1, 0, 0, 0, 0, 0, 0, 0, SUB));
        tick();
        exp_retired = exp_retired + 16'd1;
        check_outs("beq fetch", IDLE);

        // BNE
        apply_stimulus(7'b1100011, 10'b0000000_001);
        tick();
        tick();
        zero_flag = 1'b1;
        #1;
        check_outs("bne not taken", pk(1, 0, 0, 0, 0, 0, 0, 0, SUB));
        zero_flag = 1'b0;
        #1;
        check_outs("bne taken", pk(1, 1, 0, 0, 0, 0, 0, 0, SUB));
        tick();
        exp_retired = exp_retired + 16'd1;

        // BLT is not supported and must fall through
        apply_stimulus(7'b1100011, 10'b0000000_100);
        tick();
        tick();
        check_outs("blt fallthrough", pk(1, 0, 0, 0, 0, 0, 0, 0, SUB));
        tick();
        exp_retired = exp_retired + 16'd1;
        check_output("branch retired", retired, exp_retired);

        // Reset in the middle of a LOAD memory wait
        apply_stimulus(7'b0000011, 10'b0000000_010);
        tick();
        tick();
        tick();
        check_outs("mid-mem load", pk(0, 0, 0, 0, 1, 0, 1, 0, ADD));
        #1;
        rst = 1'b0;
        #1;
        check_outs("async reset outs", IDLE);
        check_output("async reset retired", retired, 16'd0);
        exp_retired = 16'd0;
        tick();
        check_outs("reset over edge", IDLE);
        apply_stimulus(7'b1111111, 10'b0);
        rst = 1'b1;

        // Illegal opcode traps until reset
        tick();
        check_outs("illegal decode", IDLE);
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_ready = 1'b1;
            zero_flag = 1'b1;
            check_outs($sformatf("trap hold%0d", i), pk(0, 0, 0, 0, 0, 0, 0, 1, AND_));
        end
        check_output("trap retired", retired, 16'd0);
        mem_ready = 1'b0;
        zero_flag = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check_outs("trap reset outs", IDLE);
        tick();
        apply_stimulus(7'b0110011, 10'b0);
        rst = 1'b1;
        run_alu_insn("post-trap add", 7'b0110011, 10'b0000000_000, ADD, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  reset; asynchronous and active-low (0 = reset).
REQ-003 SHALL have port: inst_control  input  7  opcode field, inst[6:0].
REQ-004 SHALL have port: inst_alu  input  10  {funct7, funct3}, inst[31:25], inst[14:12].
REQ-005 SHALL have port: zero_flag  input  1  ALU zero result.
REQ-006 SHALL have port: mem_ready  input  1  data-memory access completes this cycle.
REQ-007 SHALL have ports: pc_en, sel, sel2, regw, alu_src, memw, memr  output  1 each.
- pc_en: PC load enable.
- sel: PC mux, 0 = PC+4, 1 = PC+imm.
- sel2: writeback mux, 0 = ALU, 1 = memory.
- regw, alu_src, memw, memr: datapath strobes.
REQ-008 SHALL have port: alu_op  output  4  ALU operation code.
REQ-009 SHALL have port: trap  output  1  illegal-opcode halt indicator.
REQ-010 SHALL have port: retired  output  16  count of completed instructions.

Function
REQ-011 SHALL implement a state machine with states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-012 SHALL latch inst_control and inst_alu on the FETCH->DECODE edge; all later decode SHALL use the latched copy.
REQ-013 SHALL transition FETCH->DECODE unconditionally.
REQ-014 SHALL decode in DECODE:
- opcode 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH) -> EXEC.
- any other opcode -> TRAP.
REQ-015 SHALL transition out of EXEC as follows: R/I -> WB; LOAD/STORE -> MEM; BRANCH -> FETCH.
REQ-016 SHALL remain in MEM while mem_ready=0, with no cycle limit; when mem_ready=1, LOAD -> WB and STORE -> FETCH.
REQ-017 SHALL transition WB -> FETCH unconditionally; TRAP SHALL be held until reset.
REQ-018 SHALL drive all outputs as Moore functions of state and latched fields; outputs not named for a state SHALL be 0.
REQ-019 SHALL encode alu_op as ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLL 0100, SRL 0101, SRA 0111, SLT 1000.
- R: funct3/funct7[5] select the op; funct7=0100000 selects SUB/SRA.
- I-ALU: funct7 is ignored except for SRAI.
- LOAD/STORE: ADD.
- BRANCH: SUB.
REQ-020 SHALL drive alu_src=1 in EXEC/MEM/WB for I-ALU, LOAD and STORE, else 0; alu_op SHALL hold its EXEC value through MEM and WB.
REQ-021 SHALL assert memr (LOAD) or memw (STORE) in every MEM cycle.
REQ-022 SHALL assert pc_en for exactly one cycle per instruction, with sel=0, in:
- the WB cycle;
- the MEM cycle with mem_ready=1 for STORE.
REQ-023 SHALL, in WB, assert regw=1, with sel2=1 for LOAD and 0 otherwise.
REQ-024 SHALL, in BRANCH EXEC, assert pc_en=1 with sel = zero_flag for funct3=000 (BEQ) and sel = ~zero_flag for funct3=001 (BNE).
REQ-025 SHALL treat other branch funct3 values as not-taken.
REQ-026 SHALL increment retired (wrapping FFFF->0000) on every cycle in which pc_en=1.
REQ-027 SHALL assert trap=1 in TRAP, with pc_en, regw, memw and memr all 0.

Reset
REQ-028 SHALL, on rst=0 at any time (including mid-MEM or in TRAP), immediately enter FETCH and clear the latched fields, retired, trap and all strobes to 0, with alu_op=0000.
REQ-029 SHALL leave FETCH on the first rising clk after rst returns to 1.

Verification
REQ-030 R-type ADD (opcode 0110011, inst_alu=0) -> states F,D,E,W; WB has regw=1, sel2=0, pc_en=1, alu_op=0010; retired=1.
REQ-031 LOAD with mem_ready low for 3 cycles -> memr=1 for 4 MEM cycles, then WB with sel2=1, regw=1; memw=0 throughout.
REQ-032 BEQ with zero_flag=1 -> EXEC has pc_en=1, sel=1, alu_op=0110; BNE with zero_flag=1 -> sel=0; regw=0 in both cases.
REQ-033 STORE with mem_ready=1 first MEM cycle -> memw=1 and pc_en=1 in that cycle; next state FETCH; regw never 1.
REQ-034 Opcode 1111111 -> TRAP with trap=1 indefinitely; rst=0 pulse -> FETCH, trap=0, retired=0.
REQ-035 rst asserted mid-MEM of a LOAD -> memr=0 without waiting for a clock edge; no regw pulse occurs.
